// File: rtl/debounce.sv
// Push-button debouncer: 2-flop synchronizer, 2^D-clock sample prescaler and an
// L-sample qualification counter that accepts a new level, with rise/fall strobes.
module debounce #(
  parameter int D = 6,
  parameter int L = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  logic          sync_reg [0:1];
  logic [D-1:0]  pre_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          db_reg;
  logic          db_next;
  logic          rise_reg;
  logic          rise_next;
  logic          fall_reg;
  logic          fall_next;
  logic          s;
  logic          tick;

  // Synchronizer chain; stage 0 takes the raw pin, later stages take the previous stage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= in;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign s    = sync_reg[1];
  assign tick = &pre_reg;

  // Free-running prescaler; natural D-bit wrap gives the 0..2^D-1 sequence.
  always_ff @(posedge clk) begin
    if (rst) pre_reg <= '0;
    else     pre_reg <= pre_reg + D'(1);
  end

  always_comb begin
    cnt_next  = cnt_reg;
    db_next   = db_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (tick) begin
      if (s == db_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
        db_next   = s;
        cnt_next  = '0;
        rise_next = s;
        fall_next = ~s;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      db_reg   <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      db_reg   <= db_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign db   = db_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: directed scenarios plus random hold times, with a cycle-level
// reference model derived from the sampling rules compared on every falling edge.
module tb_debounce;

  localparam int D = 6;
  localparam int L = 8;
  localparam int P = 1 << D;
  localparam int LAT_MIN = (L - 1) * P + 2;
  localparam int LAT_MAX = L * P + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic db, rise, fall;

  int n_chk  = 0;
  int n_fail = 0;

  debounce #(.D(D), .L(L)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .db  (db),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  // Reference: t counts clocks since reset release; a sample is taken when t mod 2^D
  // is 2^D-1 and sees the pin as it was two clocks earlier. The level is accepted
  // once L consecutive samples disagree with the current output.
  int   t      = 0;
  logic in_d1  = 1'b0;
  logic in_d2  = 1'b0;
  int   streak = 0;
  logic m_db   = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; in_d1 = 1'b0; in_d2 = 1'b0; streak = 0;
      m_db = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if ((t % P) == P - 1) begin
        if (in_d2 == m_db) begin
          streak = 0;
        end else begin
          streak = streak + 1;
          if (streak == L) begin
            m_db   = in_d2;
            m_rise = in_d2;
            m_fall = !in_d2;
            streak = 0;
          end
        end
      end
      in_d2 = in_d1;
      in_d1 = in;
      t = t + 1;
    end
  end

  always @(negedge clk) begin
    n_chk++;
    assert (db === m_db && rise === m_rise && fall === m_fall && !(rise && fall))
      else begin
        n_fail++;
        $error("FAIL cycle_model t=%0d: observed db/rise/fall=%b%b%b expected %b%b%b",
               t, db, rise, fall, m_db, m_rise, m_fall);
      end
  end

  int rise_cnt, fall_cnt, first_chg;

  task automatic run(input int n);
    logic db_start;
    db_start  = db;
    rise_cnt  = 0;
    fall_cnt  = 0;
    first_chg = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (rise === 1'b1) rise_cnt++;
      if (fall === 1'b1) fall_cnt++;
      if (first_chg < 0 && db !== db_start) first_chg = i;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
  endtask

  int tog_pulses;
  int seg_len;

  initial begin
    repeat (4) @(negedge clk);
    check("reset_db", db, 0);
    check("reset_rise_fall", rise | fall, 0);
    rst = 1'b0;

    run(10000);
    check("idle_rise", rise_cnt, 0);
    check("idle_fall", fall_cnt, 0);
    check("idle_db", db, 0);

    in = 1'b1;
    run(8000);
    check("press_rise", rise_cnt, 1);
    check("press_fall", fall_cnt, 0);
    check_range("press_latency", first_chg, LAT_MIN, LAT_MAX);
    check("press_db", db, 1);

    in = 1'b0;
    run(16000);
    check("release_fall", fall_cnt, 1);
    check("release_rise", rise_cnt, 0);
    check_range("release_latency", first_chg, LAT_MIN, LAT_MAX);
    check("release_db", db, 0);

    in = 1'b1;
    run(1000);
    check("glitch_setup_db", db, 1);
    in = 1'b0;
    run(160);
    check("glitch_low_pulses", rise_cnt + fall_cnt, 0);
    in = 1'b1;
    run(1000);
    check("glitch_after_pulses", rise_cnt + fall_cnt, 0);
    check("glitch_db", db, 1);

    in = 1'b0;
    run(1000);
    check("toggle_setup_db", db, 0);
    tog_pulses = 0;
    for (int k = 0; k < 50; k++) begin
      in = (k % 2 == 0);
      run(100);
      tog_pulses += rise_cnt + fall_cnt;
    end
    check("toggle_pulses", tog_pulses, 0);
    check("toggle_db", db, 0);
    in = 1'b1;
    run(1000);
    check("settle_rise", rise_cnt, 1);
    check("settle_fall", fall_cnt, 0);
    check_range("settle_latency", first_chg, LAT_MIN, LAT_MAX);

    in = 1'b0;
    run(1000);
    check("midq_setup_db", db, 0);
    in = 1'b1;
    run(250);
    check("midq_pending_db", db, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midq_reset_db", db, 0);
    check("midq_reset_rise", rise, 0);
    @(negedge clk);
    rst = 1'b0;
    run(600);
    check("midq_rise", rise_cnt, 1);
    check_range("midq_latency", first_chg, LAT_MIN, LAT_MAX);

    rst = 1'b1;
    @(negedge clk);
    check("high_reset_db", db, 0);
    @(negedge clk);
    rst = 1'b0;
    run(600);
    check("high_reset_rise", rise_cnt, 1);
    check("high_reset_fall", fall_cnt, 0);
    check_range("high_reset_latency", first_chg, LAT_MIN, LAT_MAX);

    for (int k = 0; k < 30; k++) begin
      in = 1'($urandom_range(0, 1));
      seg_len = int'($urandom_range(20, 700));
      run(seg_len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
